// File: rtl/sysarr_collect_if.sv
// rtl/sysarr_collect_if.sv - row-major C element stream between the collector and its consumer
interface sysarr_collect_if #(
    parameter int n = 31
);
    logic         out_valid;
    logic         out_ready;
    logic [n:0]   out_data;
    logic [1:0]   out_row;
    logic [1:0]   out_col;

    modport master (
        output out_valid,
        output out_data,
        output out_row,
        output out_col,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_row,
        input  out_col,
        output out_ready
    );
endinterface

// File: rtl/sysarr_collect.sv
// rtl/sysarr_collect.sv - samples skewed sysarr result lanes into a 3x3 C and streams it row-major (SYSARR_COLLECT_ACC_EN: accumulate)
module sysarr_collect #(
    parameter int n   = 31,
    parameter int LAT = 6
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic [n:0]        c53,
    input  logic [n:0]        c54,
    input  logic [n:0]        c55,
    input  logic [n:0]        c45,
    input  logic [n:0]        c35,
`ifdef SYSARR_COLLECT_ACC_EN
    input  logic              acc_clr,
`endif
    sysarr_collect_if.master  stream,
    output logic              busy,
    output logic              done,
    output logic              start_err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        CAPTURE = 2'd2,
        DRAIN   = 2'd3
    } state_t;

    // WAIT lasts LAT-1 cycles, so its counter stops at LAT-2; LAT=1 skips WAIT
    localparam logic [5:0] WAIT_LAST = (LAT > 1) ? 6'(LAT - 2) : 6'd0;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [3:0]  idx_q, idx_d;
    logic        done_q, done_d;
    logic        err_q;

    logic [n:0]  mem   [9];
    logic [n:0]  lane  [9];
    logic [8:0]  wr_en;

    // Each C element always comes from the lane of its own diagonal
    assign lane[0] = c55;
    assign lane[1] = c45;
    assign lane[2] = c35;
    assign lane[3] = c54;
    assign lane[4] = c55;
    assign lane[5] = c45;
    assign lane[6] = c53;
    assign lane[7] = c54;
    assign lane[8] = c55;

    always_comb begin
        wr_en = '0;
        if (state_q == CAPTURE) begin
            case (cnt_q)
                6'd0: wr_en[0] = 1'b1;
                6'd1: begin wr_en[1] = 1'b1; wr_en[3] = 1'b1; end
                6'd2: begin wr_en[2] = 1'b1; wr_en[6] = 1'b1; end
                6'd3: wr_en[4] = 1'b1;
                6'd4: begin wr_en[5] = 1'b1; wr_en[7] = 1'b1; end
                6'd6: wr_en[8] = 1'b1;
                default: wr_en = '0;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = (LAT == 1) ? CAPTURE : WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == WAIT_LAST) begin
                    cnt_d   = '0;
                    state_d = CAPTURE;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            CAPTURE: begin
                if (cnt_q == 6'd6) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = DRAIN;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            DRAIN: begin
                if (stream.out_ready) begin
                    if (idx_q == 4'd8) begin
                        idx_d   = '0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
            if (start && state_q != IDLE) begin
                err_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < 9; k++) begin
                mem[k] <= '0;
            end
        end else begin
`ifdef SYSARR_COLLECT_ACC_EN
            for (int k = 0; k < 9; k++) begin
                if (state_q == IDLE && acc_clr) begin
                    mem[k] <= '0;
                end else if (wr_en[k]) begin
                    mem[k] <= mem[k] + lane[k];
                end
            end
`else
            for (int k = 0; k < 9; k++) begin
                if (wr_en[k]) begin
                    mem[k] <= lane[k];
                end
            end
`endif
        end
    end

    always_comb begin
        stream.out_row = 2'd0;
        stream.out_col = 2'd0;
        if (state_q == DRAIN) begin
            case (idx_q)
                4'd0: begin stream.out_row = 2'd0; stream.out_col = 2'd0; end
                4'd1: begin stream.out_row = 2'd0; stream.out_col = 2'd1; end
                4'd2: begin stream.out_row = 2'd0; stream.out_col = 2'd2; end
                4'd3: begin stream.out_row = 2'd1; stream.out_col = 2'd0; end
                4'd4: begin stream.out_row = 2'd1; stream.out_col = 2'd1; end
                4'd5: begin stream.out_row = 2'd1; stream.out_col = 2'd2; end
                4'd6: begin stream.out_row = 2'd2; stream.out_col = 2'd0; end
                4'd7: begin stream.out_row = 2'd2; stream.out_col = 2'd1; end
                4'd8: begin stream.out_row = 2'd2; stream.out_col = 2'd2; end
                default: begin stream.out_row = 2'd0; stream.out_col = 2'd0; end
            endcase
        end
    end

    assign stream.out_valid = (state_q == DRAIN);
    assign stream.out_data  = (state_q == DRAIN && idx_q < 4'd9) ? mem[idx_q] : '0;
    assign busy             = (state_q != IDLE);
    assign done             = done_q;
    assign start_err        = err_q;

endmodule

// File: tb/tb_sysarr_collect.sv
// tb/tb_sysarr_collect.sv - directed self-checking bench for sysarr_collect
module tb_sysarr_collect;
    localparam int N   = 31;
    localparam int LAT = 6;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        start;
    logic [N:0]  c53, c54, c55, c45, c35;
`ifdef SYSARR_COLLECT_ACC_EN
    logic        acc_clr;
`endif
    logic        busy, done, start_err;

    int n_cmp = 0;
    int n_bad = 0;

    sysarr_collect_if #(.n(N)) s ();

    sysarr_collect #(.n(N), .LAT(LAT)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .start     (start),
        .c53       (c53),
        .c54       (c54),
        .c55       (c55),
        .c45       (c45),
        .c35       (c35),
`ifdef SYSARR_COLLECT_ACC_EN
        .acc_clr   (acc_clr),
`endif
        .stream    (s.master),
        .busy      (busy),
        .done      (done),
        .start_err (start_err)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Lane values for capture slot t; anything off-schedule is junk the DUT must ignore
    task automatic drive_lanes(input logic [31:0] m [9], input int t);
        c53 = 32'hA5A5_0053 + t;
        c54 = 32'hA5A5_0054 + t;
        c55 = 32'hA5A5_0055 + t;
        c45 = 32'hA5A5_0045 + t;
        c35 = 32'hA5A5_0035 + t;
        case (t)
            0: c55 = m[0];
            1: begin c45 = m[1]; c54 = m[3]; end
            2: begin c35 = m[2]; c53 = m[6]; end
            3: c55 = m[4];
            4: begin c45 = m[5]; c54 = m[7]; end
            6: c55 = m[8];
            default: ;
        endcase
    endtask

    task automatic clr();
`ifdef SYSARR_COLLECT_ACC_EN
        acc_clr = 1'b1;
        tick();
        acc_clr = 1'b0;
`endif
    endtask

    // stall: 0 = always ready, 1 = ready on odd cycles; abort_at >= 0 resets mid-run
    task automatic run(input string tag, input logic [31:0] m [9], input logic [31:0] e [9],
                       input int stall, input bit extra, input int abort_at);
        int  exp_idx = 0;
        int  first_v = -1;
        bit  fin = 1'b0;
        bit  rdy;
        for (int c = 0; c < 400 && !fin; c++) begin
            rdy = (stall == 0) ? 1'b1 : (c % 2 == 1);
            start = (c == 0) || (extra && c == LAT + 2);
            if (extra && s.out_valid && rdy && exp_idx == 8) start = 1'b1;
            drive_lanes(m, c - LAT);
            s.out_ready = rdy;
            if (c == abort_at) begin
                start   = 1'b0;
                reset_n = 1'b0;
                #1;
                chk({tag, "_abort_busy"}, {31'd0, busy}, 32'd0);
                chk({tag, "_abort_valid"}, {31'd0, s.out_valid}, 32'd0);
                chk({tag, "_abort_data"}, s.out_data, 32'd0);
                reset_n = 1'b1;
                tick();
                return;
            end
            #1;
            if (s.out_valid) begin
                if (first_v < 0) first_v = c;
                if (exp_idx < 9) begin
                    chk({tag, "_data"}, s.out_data, e[exp_idx]);
                    chk({tag, "_row"}, {30'd0, s.out_row}, exp_idx / 3);
                    chk({tag, "_col"}, {30'd0, s.out_col}, exp_idx % 3);
                    if (rdy) exp_idx++;
                end else begin
                    chk({tag, "_overrun"}, exp_idx, 9);
                end
            end
            if (done) begin
                chk({tag, "_count"}, exp_idx, 9);
                chk({tag, "_done_valid"}, {31'd0, s.out_valid}, 32'd0);
                chk({tag, "_done_busy"}, {31'd0, busy}, 32'd0);
                chk({tag, "_first_valid"}, first_v, LAT + 7);
                if (stall == 0) chk({tag, "_done_cycle"}, c, LAT + 16);
                fin = 1'b1;
            end
            tick();
        end
        start = 1'b0;
        s.out_ready = 1'b1;
        chk({tag, "_timeout"}, {31'd0, fin}, 32'd1);
    endtask

    logic [31:0] up   [9];
    logic [31:0] down [9];
`ifdef SYSARR_COLLECT_ACC_EN
    logic [31:0] dbl  [9];
    logic [31:0] ones [9];
    logic [31:0] wrap [9];
    logic [31:0] zero [9];
`endif

    initial begin
        for (int k = 0; k < 9; k++) begin
            up[k]   = 32'(k + 1);
            down[k] = 32'(9 - k);
`ifdef SYSARR_COLLECT_ACC_EN
            dbl[k]  = 32'(2 * (k + 1));
            ones[k] = 32'd1;
            wrap[k] = 32'hFFFF_FFFF;
            zero[k] = 32'd0;
`endif
        end
        reset_n = 1'b0;
        start = 1'b0;
        s.out_ready = 1'b1;
        c53 = '0; c54 = '0; c55 = '0; c45 = '0; c35 = '0;
`ifdef SYSARR_COLLECT_ACC_EN
        acc_clr = 1'b0;
`endif
        tick();
        tick();
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_err", {31'd0, start_err}, 32'd0);
        chk("rst_valid", {31'd0, s.out_valid}, 32'd0);
        chk("rst_data", s.out_data, 32'd0);
        reset_n = 1'b1;
        tick();

        run("t1", up, up, 0, 1'b0, -1);
        tick();
        clr();
        run("t2", up, up, 1, 1'b0, -1);
        chk("t2_err", {31'd0, start_err}, 32'd0);
        clr();
        run("t3", down, down, 0, 1'b1, -1);
        chk("t3_err", {31'd0, start_err}, 32'd1);
        repeat (3) tick();
        chk("t3_err_sticky", {31'd0, start_err}, 32'd1);

        run("t4a", up, up, 0, 1'b0, LAT + 3);
        chk("t4_err_cleared", {31'd0, start_err}, 32'd0);
        run("t4", down, down, 0, 1'b0, -1);

`ifdef SYSARR_COLLECT_ACC_EN
        clr();
        run("t6a", up, up, 0, 1'b0, -1);
        run("t6b", up, dbl, 0, 1'b0, -1);
        clr();
        run("t6c", up, up, 0, 1'b0, -1);
        clr();
        run("t6d", ones, ones, 0, 1'b0, -1);
        run("t6e", wrap, zero, 0, 1'b0, -1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
